// File: rtl/window3x3_stream.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 register
// window; each frame ends with an internal flush so the last row and column are emitted.
module window3x3_stream #(
   parameter int DATA_W      = 8,
   parameter int IMG_W       = 320,
   parameter int IMG_H       = 240,
   parameter int BORDER_MODE = 0,
   parameter int XW          = $clog2(IMG_W),
   parameter int YW          = $clog2(IMG_H)
) (
   input  logic                  pclk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic                  in_sof,
   input  logic [DATA_W-1:0]     in_data,
   output logic                  in_ready,
   output logic                  win_valid,
   output logic [9*DATA_W-1:0]   win_data,
   output logic [XW-1:0]         win_x,
   output logic [YW-1:0]         win_y,
   output logic                  frame_done,
   output logic                  sync_err
);

   // Beat row counter runs one row past the image plus one extra beat for the flush.
   localparam int              BYW          = $clog2(IMG_H + 2);
   localparam logic [XW-1:0]   X_MAX        = XW'(IMG_W - 1);
   localparam logic [YW-1:0]   Y_MAX        = YW'(IMG_H - 1);
   localparam logic [BYW-1:0]  BY_LAST_PIX  = BYW'(IMG_H - 1);
   localparam logic [BYW-1:0]  BY_FLUSH_END = BYW'(IMG_H + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [XW-1:0]         r_bx;
   logic [BYW-1:0]        r_by;
   logic [XW-1:0]         r_cx;
   logic [YW-1:0]         r_cy;
   logic [DATA_W-1:0]     r_lb_old [IMG_W];
   logic [DATA_W-1:0]     r_lb_new [IMG_W];
   logic [DATA_W-1:0]     r_win    [3][3];
   logic [DATA_W-1:0]     w_nwin   [3][3];
   logic                  r_vld_p1;
   logic [9*DATA_W-1:0]   r_win_data_p1;
   logic [XW-1:0]         r_win_x_p1;
   logic [YW-1:0]         r_win_y_p1;
   logic                  r_frame_done_p1;
   logic                  r_sync_err_p1;

   logic                  w_sof;
   logic                  w_beat;
   logic                  w_emit;
   logic [XW-1:0]         w_bx;
   logic [BYW-1:0]        w_by;
   logic [DATA_W-1:0]     w_data;
   logic                  w_col_end;
   logic                  w_last_pix;
   logic                  w_flush_end;
   logic [DATA_W-1:0]     w_lb_old_rd;
   logic [DATA_W-1:0]     w_lb_new_rd;
   logic                  w_out_l;
   logic                  w_out_r;
   logic                  w_out_t;
   logic                  w_out_b;
   logic [9*DATA_W-1:0]   w_win_out;

   function automatic logic [DATA_W-1:0] f_border_tap(input logic [DATA_W-1:0] tap,
                                                      input logic [DATA_W-1:0] ctr,
                                                      input logic              outside);
      if (!outside)
         return tap;
      return (BORDER_MODE == 1) ? ctr : '0;
   endfunction

   assign w_sof       = in_valid & in_sof & (r_state != S_FLUSH);
   assign w_beat      = w_sof | (r_state == S_FLUSH) | ((r_state == S_RUN) & in_valid);
   assign w_bx        = w_sof ? '0 : r_bx;
   assign w_by        = w_sof ? '0 : r_by;
   assign w_data      = (r_state == S_FLUSH) ? '0 : in_data;
   assign w_col_end   = (w_bx == X_MAX);
   assign w_emit      = w_beat & ((w_by >= BYW'(2)) | ((w_by == BYW'(1)) & (w_bx != '0)));
   assign w_last_pix  = (r_state == S_RUN) & in_valid & ~in_sof & w_col_end & (r_by == BY_LAST_PIX);
   assign w_flush_end = (r_state == S_FLUSH) & (r_by == BY_FLUSH_END);

   always_ff @(posedge pclk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (w_sof)       w_state_nxt = S_RUN;
         S_RUN:   if (w_last_pix)  w_state_nxt = S_FLUSH;
         S_FLUSH: if (w_flush_end) w_state_nxt = S_IDLE;
         default:                  w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (r_state != S_FLUSH);
   end

   // Beat position counters (line-buffer column) and centre coordinates of the next window.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         r_bx <= '0;
         r_by <= '0;
         r_cx <= '0;
         r_cy <= '0;
      end else if (w_beat) begin
         r_bx <= w_col_end ? '0 : w_bx + 1'b1;
         r_by <= w_col_end ? w_by + 1'b1 : w_by;
         if (w_sof) begin
            r_cx <= '0;
            r_cy <= '0;
         end else if (w_emit) begin
            if (r_cx == X_MAX) begin
               r_cx <= '0;
               r_cy <= (r_cy == Y_MAX) ? '0 : r_cy + 1'b1;
            end else begin
               r_cx <= r_cx + 1'b1;
            end
         end
      end
   end

   assign w_lb_old_rd = r_lb_old[w_bx];
   assign w_lb_new_rd = r_lb_new[w_bx];

   always_ff @(posedge pclk) begin
      if (w_beat) begin
         r_lb_old[w_bx] <= w_lb_new_rd;
         r_lb_new[w_bx] <= w_data;
      end
   end

   always_comb begin
      for (int r = 0; r < 3; r++) begin
         w_nwin[r][0] = r_win[r][1];
         w_nwin[r][1] = r_win[r][2];
      end
      w_nwin[0][2] = w_lb_old_rd;
      w_nwin[1][2] = w_lb_new_rd;
      w_nwin[2][2] = w_data;
   end

   always_ff @(posedge pclk) begin
      if (w_beat)
         r_win <= w_nwin;
   end

   // Border taps are decided from the centre coordinates, never from buffer contents.
   assign w_out_l = (r_cx == '0);
   assign w_out_r = (r_cx == X_MAX);
   assign w_out_t = (r_cy == '0);
   assign w_out_b = (r_cy == Y_MAX);

   always_comb begin
      w_win_out = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            w_win_out[(8 - (r * 3 + c)) * DATA_W +: DATA_W] =
               f_border_tap(w_nwin[r][c], w_nwin[1][1],
                            ((r == 0) && w_out_t) || ((r == 2) && w_out_b) ||
                            ((c == 0) && w_out_l) || ((c == 2) && w_out_r));
         end
      end
   end

   // Output stage: one registered window per emitting beat.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         r_vld_p1        <= 1'b0;
         r_frame_done_p1 <= 1'b0;
         r_sync_err_p1   <= 1'b0;
         r_win_data_p1   <= '0;
         r_win_x_p1      <= '0;
         r_win_y_p1      <= '0;
      end else begin
         r_vld_p1        <= w_emit;
         r_frame_done_p1 <= w_emit & w_flush_end;
         r_sync_err_p1   <= w_sof & (r_state == S_RUN);
         if (w_emit) begin
            r_win_data_p1 <= w_win_out;
            r_win_x_p1    <= r_cx;
            r_win_y_p1    <= r_cy;
         end
      end
   end

   assign win_valid  = r_vld_p1;
   assign win_data   = r_win_data_p1;
   assign win_x      = r_win_x_p1;
   assign win_y      = r_win_y_p1;
   assign frame_done = r_frame_done_p1;
   assign sync_err   = r_sync_err_p1;

endmodule
